conv_relu_pool_stream: RTL

CONV_RELU_POOL_STREAM -- requirements
Module: conv_relu_pool_stream

---
 rtl/accel_pkg.sv | 22 ++
 rtl/conv_window.sv | 50 +++++
 rtl/conv_relu_pool_stream.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the streaming conv/ReLU/max-pool accelerator:
// FSM state encoding, default geometry and the accumulator width helper.
package accel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEF_N  = 10;
   localparam int DEF_K  = 3;
   localparam int DEF_P  = 2;
   localparam int DEF_DW = 16;
   localparam int DEF_OW = 16;

   // A K*K sum of DW x DW signed products needs 2*DW bits plus growth for the adds.
   function automatic int acc_width(input int dw, input int k);
      return 2 * dw + $clog2(k * k);
   endfunction

endpackage

// File: rtl/conv_window.sv
// K-1 row line buffer feeding a K x K sliding window of pixels.
// Window tap (i, j) sits at flat index i*K+j, row 0 / column 0 being the oldest.
module conv_window
   import accel_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int K  = DEF_K,
   parameter int DW = DEF_DW,
   parameter int CW = $clog2(DEF_N)
) (
   input  logic               clk,
   input  logic               shift,
   input  logic [CW-1:0]      col,
   input  logic [DW-1:0]      pixel,
   output logic [K*K*DW-1:0]  window
);

   logic [DW-1:0] line_mem [0:K-2][0:N-1];
   logic [DW-1:0] win      [0:K-1][0:K-1];

   // On each accepted pixel, push the column into the line buffer and slide the window left.
   always_ff @(posedge clk) begin
      if (shift) begin
         line_mem[0][col] <= pixel;
         for (int j = 1; j < K - 1; j++) begin
            line_mem[j][col] <= line_mem[j-1][col];
         end
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
               win[i][j] <= win[i][j+1];
            end
         end
         for (int i = 0; i < K - 1; i++) begin
            win[i][K-1] <= line_mem[K-2-i][col];
         end
         win[K-1][K-1] <= pixel;
      end
   end

   // Flatten the window row-major so it lines up with the packed kernel taps.
   always_comb begin
      window = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            window[(i*K+j)*DW +: DW] = win[i][j];
         end
      end
   end

endmodule

// File: rtl/conv_relu_pool_stream.sv
// Streaming K x K convolution -> ReLU -> P x P max-pool over an N x N frame.
// Pipeline: window (accept edge) -> conv register -> ReLU register -> pool/output register.
// Build option: define OUT_SAT_EN to clamp pooled values to the output range
// instead of keeping their low OW bits.
module conv_relu_pool_stream
   import accel_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int K  = DEF_K,
   parameter int P  = DEF_P,
   parameter int DW = DEF_DW,
   parameter int OW = DEF_OW
) (
   input  logic               clk,
   input  logic               global_rst,
   input  logic               ce,
   input  logic [K*K*DW-1:0]  weight1,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      activation,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OW-1:0]      data_out,
   output logic               end_op,
   output logic               busy
);

   localparam int M  = N - K + 1;
   localparam int Q  = M / P;
   localparam int AW = acc_width(DW, K);
   localparam int CW = $clog2(N);
   localparam int QW = (Q > 1) ? $clog2(Q) : 1;

   state_t state, state_next;
   logic adv, accept, end_hs, last_pixel, done_seen;
   logic [CW-1:0] row, col;

   logic [K*K*DW-1:0]     window;
   logic signed [AW-1:0]  conv_sum, conv_q;
   logic                  s0_valid, s1_valid, s2_valid;
   logic [CW-1:0]         s0_row, s0_col, s1_row, s1_col, s2_row, s2_col;
   logic [AW-1:0]         relu_q;

   logic [AW-1:0]  pmax [0:Q-1];
   logic [QW-1:0]  pool_row, pool_col;
   logic [CW-1:0]  off_row, off_col;
   logic           blk_first, blk_last, frame_last;
   logic [AW-1:0]  prev_max, cand;
   logic [OW-1:0]  pooled;

   assign adv        = ce && (!out_valid || out_ready);
   assign in_ready   = adv && (state != DRAIN);
   assign accept     = in_valid && in_ready;
   assign end_hs     = adv && out_valid && out_ready && end_op;
   assign last_pixel = (row == CW'(N-1)) && (col == CW'(N-1));
   assign busy       = (state != IDLE);

   // Frame state register.
   always_ff @(posedge clk) begin
      if (global_rst) state <= IDLE;
      else            state <= state_next;
   end

   // Frame sequencing; if the final pooled result already left before the last pixel, skip DRAIN.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept) state_next = RUN;
         RUN:   if (accept && last_pixel) state_next = (done_seen || end_hs) ? IDLE : DRAIN;
         DRAIN: if (end_hs) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Remember an end_op handshake that happens while pixels are still arriving.
   always_ff @(posedge clk) begin
      if (global_rst)                done_seen <= 1'b0;
      else if (state_next == IDLE)   done_seen <= 1'b0;
      else if (end_hs)               done_seen <= 1'b1;
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk) begin
      if (global_rst) begin
         row <= '0;
         col <= '0;
      end else if (accept) begin
         if (col == CW'(N-1)) begin
            col <= '0;
            row <= (row == CW'(N-1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   conv_window #(.N(N), .K(K), .DW(DW), .CW(CW)) u_window (
      .clk    (clk),
      .shift  (accept),
      .col    (col),
      .pixel  (activation),
      .window (window)
   );

   // Signed dot product of the current window with the kernel.
   always_comb begin
      conv_sum = '0;
      for (int t = 0; t < K*K; t++) begin
         conv_sum = conv_sum + AW'($signed(window[t*DW +: DW]) * $signed(weight1[t*DW +: DW]));
      end
   end

   // Window-valid, conv and ReLU stages; conv coordinates outside the pooled area are dropped.
   always_ff @(posedge clk) begin
      if (global_rst) begin
         s0_valid <= 1'b0;
         s0_row   <= '0;
         s0_col   <= '0;
         s1_valid <= 1'b0;
         s1_row   <= '0;
         s1_col   <= '0;
         conv_q   <= '0;
         s2_valid <= 1'b0;
         s2_row   <= '0;
         s2_col   <= '0;
         relu_q   <= '0;
      end else if (adv) begin
         s0_valid <= accept && (row >= CW'(K-1)) && (col >= CW'(K-1));
         s0_row   <= row - CW'(K-1);
         s0_col   <= col - CW'(K-1);
         s1_valid <= s0_valid;
         s1_row   <= s0_row;
         s1_col   <= s0_col;
         conv_q   <= conv_sum;
         s2_valid <= s1_valid && (s1_row < CW'(Q*P)) && (s1_col < CW'(Q*P));
         s2_row   <= s1_row;
         s2_col   <= s1_col;
         relu_q   <= conv_q[AW-1] ? '0 : conv_q;
      end
   end

   // Locate the ReLU value inside its pool block and merge it with the running maximum.
   always_comb begin
      pool_row   = QW'(s2_row / CW'(P));
      pool_col   = QW'(s2_col / CW'(P));
      off_row    = s2_row % CW'(P);
      off_col    = s2_col % CW'(P);
      blk_first  = (off_row == '0) && (off_col == '0);
      blk_last   = (off_row == CW'(P-1)) && (off_col == CW'(P-1));
      frame_last = blk_last && (pool_row == QW'(Q-1)) && (pool_col == QW'(Q-1));
      prev_max   = '0;
      for (int i = 0; i < Q; i++) begin
         if (pool_col == QW'(i)) prev_max = pmax[i];
      end
      cand = (blk_first || (relu_q > prev_max)) ? relu_q : prev_max;
   end

   // Fit the pooled maximum into the output width.
   always_comb begin
      pooled = OW'(cand);
`ifdef OUT_SAT_EN
      if (|(cand >> OW)) pooled = '1;
`endif
   end

   // Partial maxima for the pooled row currently being built.
   always_ff @(posedge clk) begin
      if (global_rst) begin
         for (int i = 0; i < Q; i++) pmax[i] <= '0;
      end else if (adv && s2_valid) begin
         for (int i = 0; i < Q; i++) begin
            if (pool_col == QW'(i)) pmax[i] <= cand;
         end
      end
   end

   // Output register; stalls (adv low) keep it frozen under backpressure.
   always_ff @(posedge clk) begin
      if (global_rst) begin
         out_valid <= 1'b0;
         end_op    <= 1'b0;
         data_out  <= '0;
      end else if (adv) begin
         out_valid <= s2_valid && blk_last;
         end_op    <= s2_valid && frame_last;
         if (s2_valid && blk_last) data_out <= pooled;
      end
   end

endmodule
